// File: rtl/z80_bus_initiator_pkg.sv
`default_nettype none
// z80_bus_initiator_pkg: op codes, FSM state encodings and defaults for the CPC bus initiator.
// Revision 1.0
package z80_bus_initiator_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    OP_MEM_RD  = 2'd0,
    OP_MEM_WR  = 2'd1,
    OP_IO_WR   = 2'd2,
    OP_REFRESH = 2'd3
  } bus_op_e;

  // Upper bits name the T-state, bit 0 is the phase (0 = H, cpu_clk high; 1 = L).
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_T1H  = 4'b0010,
    ST_T1L  = 4'b0011,
    ST_T2H  = 4'b0100,
    ST_T2L  = 4'b0101,
    ST_TWAH = 4'b0110,
    ST_TWAL = 4'b0111,
    ST_TWH  = 4'b1000,
    ST_TWL  = 4'b1001,
    ST_T3H  = 4'b1010,
    ST_T3L  = 4'b1011
  } bus_state_e;

  function automatic logic mem_strobe_state(input bus_state_e s);
    return s inside {ST_T1L, ST_T2H, ST_T2L, ST_TWH, ST_TWL, ST_T3H};
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_wait_timer.sv
`default_nettype none
// z80_wait_timer: counts inserted Tw states and flags when the wait limit is reached.
// Revision 1.0
module z80_wait_timer
  import z80_bus_initiator_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_b_w,
  input  logic clear,
  input  logic inc,
  output logic limit
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset_b_w) begin
    if (!reset_b_w) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 4'd1;
    end
  end

  assign limit = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/z80_bus_initiator.sv
`default_nettype none
// z80_bus_initiator: Z80-style expansion-bus master issuing MEM_RD, MEM_WR, IO_WR and REFRESH cycles.
// Revision 1.0
module z80_bus_initiator
  import z80_bus_initiator_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_b_w,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_adr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_ramdis,
  output logic        rsp_adr15,
  output logic        rsp_timeout,
  output logic        cpu_clk,
  output logic [15:0] adr,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        rfsh_b,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  input  logic        wait_b,
  input  logic        ramdis,
  input  logic        adr15_in
);

  bus_state_e state_q;
  bus_state_e state_n;
  bus_op_e    op_q;
  bus_op_e    op_n;

  logic accept;
  logic decide;
  logic wait_inc;
  logic wait_limit;
  logic timeout_hit;

  logic mreq_nx;
  logic iorq_nx;
  logic rd_nx;
  logic wr_nx;
  logic rfsh_nx;
  logic oe_nx;

  // Commands only start on an L-phase clock so the cycle opens in T1H.
  assign cmd_ready = (state_q == ST_IDLE) && !cpu_clk;
  assign accept    = cmd_valid && cmd_ready;
  assign op_n      = accept ? bus_op_e'(cmd_op) : op_q;

  z80_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset_b_w (reset_b_w),
    .clear     (accept),
    .inc       (wait_inc),
    .limit     (wait_limit)
  );

  always_comb begin
    state_n     = state_q;
    decide      = 1'b0;
    wait_inc    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_n = ST_T1H;
      ST_T1H:  state_n = ST_T1L;
      ST_T1L:  state_n = ST_T2H;
      ST_T2H:  state_n = ST_T2L;
      ST_T2L: begin
        if (op_q == OP_REFRESH)   state_n = ST_IDLE;
        else if (op_q == OP_IO_WR) state_n = ST_TWAH;
        else                      decide  = 1'b1;
      end
      ST_TWAH: state_n = ST_TWAL;
      ST_TWAL: decide  = 1'b1;
      ST_TWH:  state_n = ST_TWL;
      ST_TWL:  decide  = 1'b1;
      ST_T3H:  state_n = ST_T3L;
      ST_T3L:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (decide) begin
      if (wait_b) begin
        state_n = ST_T3H;
      end else if (wait_limit) begin
        state_n     = ST_T3H;
        timeout_hit = 1'b1;
      end else begin
        state_n  = ST_TWH;
        wait_inc = 1'b1;
      end
    end
  end

  // Strobe values for the state being entered, so the registered pins line up with it.
  always_comb begin
    mreq_nx = 1'b1;
    iorq_nx = 1'b1;
    rd_nx   = 1'b1;
    wr_nx   = 1'b1;
    rfsh_nx = 1'b1;
    oe_nx   = 1'b0;
    if (state_n != ST_IDLE) begin
      case (op_n)
        OP_MEM_RD: begin
          mreq_nx = !mem_strobe_state(state_n);
          rd_nx   = !mem_strobe_state(state_n);
        end
        OP_MEM_WR: begin
          mreq_nx = !mem_strobe_state(state_n);
          wr_nx   = !(state_n inside {ST_T2L, ST_TWH, ST_TWL, ST_T3H});
          oe_nx   = (state_n != ST_T1H);
        end
        OP_IO_WR: begin
          iorq_nx = !(state_n inside {ST_T2H, ST_T2L, ST_TWAH, ST_TWAL, ST_TWH, ST_TWL, ST_T3H});
          wr_nx   = !(state_n inside {ST_T2H, ST_T2L, ST_TWAH, ST_TWAL, ST_TWH, ST_TWL, ST_T3H});
          oe_nx   = (state_n != ST_T1H);
        end
        default: begin
          rfsh_nx = !(state_n inside {ST_T1H, ST_T1L, ST_T2H, ST_T2L});
          mreq_nx = !(state_n inside {ST_T1L, ST_T2H});
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b_w) begin
    if (!reset_b_w) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MEM_RD;
      cpu_clk     <= 1'b0;
      adr         <= 16'h0000;
      data_out    <= 8'h00;
      data_oe     <= 1'b0;
      mreq_b      <= 1'b1;
      iorq_b      <= 1'b1;
      rd_b        <= 1'b1;
      wr_b        <= 1'b1;
      rfsh_b      <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_ramdis  <= 1'b0;
      rsp_adr15   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q   <= state_n;
      cpu_clk   <= !cpu_clk;
      mreq_b    <= mreq_nx;
      iorq_b    <= iorq_nx;
      rd_b      <= rd_nx;
      wr_b      <= wr_nx;
      rfsh_b    <= rfsh_nx;
      data_oe   <= oe_nx;
      rsp_valid <= (state_q != ST_IDLE) && (state_n == ST_IDLE);
      if (accept) begin
        op_q     <= op_n;
        adr      <= cmd_adr;
        data_out <= cmd_wdata;
      end
      if (state_n == ST_T3H) begin
        if (op_q == OP_MEM_RD) rsp_rdata <= data_in;
        rsp_ramdis  <= ramdis;
        rsp_adr15   <= adr15_in;
        rsp_timeout <= timeout_hit;
      end
      // Refresh has no T3, so its bus status is taken on the way into T2H.
      if ((op_q == OP_REFRESH) && (state_n == ST_T2H)) begin
        rsp_ramdis  <= ramdis;
        rsp_adr15   <= adr15_in;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_initiator.sv
`default_nettype none
// tb_z80_bus_initiator: table-driven and randomized checks of the Z80 bus initiator.
module tb_z80_bus_initiator;

  localparam int MW = 15;
  localparam logic [1:0] RD = 2'd0;
  localparam logic [1:0] WR = 2'd1;
  localparam logic [1:0] IO = 2'd2;
  localparam logic [1:0] RF = 2'd3;

  logic        clk = 1'b0;
  logic        reset_b_w = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_adr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_ramdis;
  logic        rsp_adr15;
  logic        rsp_timeout;
  logic        cpu_clk;
  logic [15:0] adr;
  logic        mreq_b, iorq_b, rd_b, wr_b, rfsh_b;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in = 8'h0;
  logic        wait_b = 1'b1;
  logic        ramdis = 1'b0;
  logic        adr15_in = 1'b0;

  always #5 clk = ~clk;

  z80_bus_initiator #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset_b_w(reset_b_w),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ramdis(rsp_ramdis),
    .rsp_adr15(rsp_adr15), .rsp_timeout(rsp_timeout),
    .cpu_clk(cpu_clk), .adr(adr),
    .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .rfsh_b(rfsh_b),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .wait_b(wait_b), .ramdis(ramdis), .adr15_in(adr15_in)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] adr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        ramdis;
    logic        a15;
    int          nwait;   // number of wait samples that see wait_b low
    int          exp_lat;
    logic        exp_tmo;
  } vec_t;

  int        applied = 0;
  int        miscompares = 0;
  logic [7:0] model_rdata = 8'h00;
  int        ready_waits = 0;
  string     tag = "init";

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  // Reference model: Tw states actually inserted and resulting latency.
  function automatic int tw_of(input logic [1:0] op, input int n);
    if (op == RF) return 0;
    return (n > MW) ? MW : n;
  endfunction

  function automatic int lat_of(input logic [1:0] op, input int n);
    int base;
    base = (op == IO) ? 8 : (op == RF) ? 4 : 6;
    return base + 2 * tw_of(op, n);
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a, input logic [7:0] wd,
                              input logic [7:0] din, input logic rdis, input logic a15,
                              input int n, input int lat, input logic tmo);
    vec_t v;
    v.op = op; v.adr = a; v.wdata = wd; v.din = din; v.ramdis = rdis; v.a15 = a15;
    v.nwait = n; v.exp_lat = lat; v.exp_tmo = tmo;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v);
    int guard, tw, lat, first;
    int n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_oe, n_excl, n_hold;
    int e_mreq, e_iorq, e_rd, e_wr, e_rfsh, e_oe;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ready_waits = guard;
    if (!cmd_ready) begin
      check("cmd_ready_bound", 0, 1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = v.op; cmd_adr = v.adr; cmd_wdata = v.wdata;
    data_in = v.din; ramdis = v.ramdis; adr15_in = v.a15; wait_b = 1'b1;
    first = (v.op == IO) ? 6 : 4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_rfsh = 0; n_oe = 0; n_excl = 0; n_hold = 0;
    for (int k = 1; k <= 80; k++) begin
      wait_b = (v.nwait > 0 && k < first + 2 * v.nwait) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rsp_valid) begin
        lat = k - 1;
        break;
      end
      n_mreq += int'(!mreq_b); n_iorq += int'(!iorq_b); n_rd += int'(!rd_b);
      n_wr += int'(!wr_b); n_rfsh += int'(!rfsh_b); n_oe += int'(data_oe);
      if (!rd_b && !wr_b) n_excl++;
      if (!mreq_b && !iorq_b) n_excl++;
      if (adr != v.adr) n_hold++;
      if (data_oe && data_out != v.wdata) n_hold++;
      @(posedge clk);
      #1;
    end
    wait_b = 1'b1;
    tw = tw_of(v.op, v.nwait);
    if (v.op == RD) model_rdata = v.din;
    e_mreq = 0; e_iorq = 0; e_rd = 0; e_wr = 0; e_rfsh = 0; e_oe = 0;
    case (v.op)
      RD: begin e_mreq = 4 + 2 * tw; e_rd = 4 + 2 * tw; end
      WR: begin e_mreq = 4 + 2 * tw; e_wr = 2 + 2 * tw; e_oe = 5 + 2 * tw; end
      IO: begin e_iorq = 5 + 2 * tw; e_wr = 5 + 2 * tw; e_oe = 7 + 2 * tw; end
      default: begin e_rfsh = 4; e_mreq = 2; end
    endcase
    check("latency", lat, v.exp_lat);
    check("timeout", int'(rsp_timeout), int'(v.exp_tmo));
    check("rdata", int'(rsp_rdata), int'(model_rdata));
    check("ramdis", int'(rsp_ramdis), int'(v.ramdis));
    check("adr15", int'(rsp_adr15), int'(v.a15));
    check("mreq_clks", n_mreq, e_mreq);
    check("iorq_clks", n_iorq, e_iorq);
    check("rd_clks", n_rd, e_rd);
    check("wr_clks", n_wr, e_wr);
    check("rfsh_clks", n_rfsh, e_rfsh);
    check("oe_clks", n_oe, e_oe);
    check("strobe_overlap", n_excl, 0);
    check("adr_data_hold", n_hold, 0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    int hits;
    tbl[0]  = mk(RD, 16'h4000, 8'h00, 8'hA5, 1'b0, 1'b0, 0,  6,  1'b0);
    tbl[1]  = mk(RD, 16'h8123, 8'h00, 8'h3C, 1'b1, 1'b1, 0,  6,  1'b0);
    tbl[2]  = mk(IO, 16'h7FFF, 8'hC4, 8'h11, 1'b0, 1'b0, 0,  8,  1'b0);
    tbl[3]  = mk(WR, 16'hC000, 8'h5A, 8'h22, 1'b0, 1'b1, 2,  10, 1'b0);
    tbl[4]  = mk(RD, 16'h1234, 8'h00, 8'h77, 1'b0, 1'b0, 20, 36, 1'b1);
    tbl[5]  = mk(RD, 16'h2345, 8'h00, 8'h88, 1'b1, 1'b0, 15, 36, 1'b0);
    tbl[6]  = mk(RF, 16'h007F, 8'h00, 8'h99, 1'b1, 1'b1, 0,  4,  1'b0);
    tbl[7]  = mk(IO, 16'h7F89, 8'h8C, 8'h00, 1'b0, 1'b1, 3,  14, 1'b0);
    tbl[8]  = mk(RF, 16'h0011, 8'h00, 8'h00, 1'b0, 1'b1, 5,  4,  1'b0);
    tbl[9]  = mk(WR, 16'h8000, 8'hE7, 8'h00, 1'b1, 1'b0, 16, 36, 1'b1);
    tbl[10] = mk(IO, 16'hDF00, 8'h01, 8'h00, 1'b1, 1'b0, 1,  10, 1'b0);

    tag = "reset";
    repeat (3) @(negedge clk);
    check("cpu_clk", int'(cpu_clk), 0);
    check("strobes", int'({mreq_b, iorq_b, rd_b, wr_b, rfsh_b}), 31);
    check("adr", int'(adr), 0);
    check("data_out", int'(data_out), 0);
    check("data_oe", int'(data_oe), 0);
    check("rsp", int'({rsp_valid, rsp_rdata, rsp_ramdis, rsp_adr15, rsp_timeout}), 0);
    check("cmd_ready", int'(cmd_ready), 1);
    reset_b_w = 1'b1;

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      run_cmd(tbl[i]);
      if (i > 0) check("b2b_gap", ready_waits, 1);
    end

    // Reset while an IO write sits in T2L.
    tag = "abort";
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = IO; cmd_adr = 16'h7FFF; cmd_wdata = 8'hC4; wait_b = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_iorq", int'(iorq_b), 0);
    check("pre_oe", int'(data_oe), 1);
    #1 reset_b_w = 1'b0;
    #1;
    check("strobes", int'({mreq_b, iorq_b, rd_b, wr_b, rfsh_b}), 31);
    check("data_oe", int'(data_oe), 0);
    check("adr", int'(adr), 0);
    check("cpu_clk", int'(cpu_clk), 0);
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      hits += int'(rsp_valid);
    end
    reset_b_w = 1'b1;
    repeat (6) begin
      @(negedge clk);
      hits += int'(rsp_valid);
    end
    check("no_rsp", hits, 0);
    model_rdata = 8'h00;
    tag = "after_abort";
    run_cmd(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      int r;
      tag = $sformatf("rand%0d", i);
      rv.op = 2'($urandom_range(0, 3));
      rv.adr = 16'($urandom);
      rv.wdata = 8'($urandom);
      rv.din = 8'($urandom);
      rv.ramdis = 1'($urandom_range(0, 1));
      rv.a15 = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      rv.nwait = (r < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 17));
      rv.exp_lat = lat_of(rv.op, rv.nwait);
      rv.exp_tmo = (rv.op != RF) && (rv.nwait > MW);
      run_cmd(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
